blinky: RTL and testbench

BLINKY -- requirements
Module: blinky

---
 rtl/blinky.sv | 50 +++++
 tb/tb_blinky.sv | 110 +++++++++++
 2 files changed

// File: rtl/blinky.sv
// LED blinker: a half-period divider toggles the blink phase and a free-running
// PWM counter dims the LED while it is lit.
module blinky #(
  parameter int unsigned BLINK_HALF_CYCLES = 50_000_000,
  parameter int unsigned PWM_BITS          = 8,
  parameter int unsigned PWM_DUTY          = 32
) (
  input  logic clk,
  input  logic btn,
  output logic led0_b
);

  localparam int unsigned CNT_W = (BLINK_HALF_CYCLES < 2) ? 1 : $clog2(BLINK_HALF_CYCLES + 1);
  localparam int unsigned PW1   = PWM_BITS + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_CYCLES - 1);
  // One extra bit so a duty of 2^PWM_BITS means always on.
  localparam logic [PW1-1:0]   DUTY     = PW1'(PWM_DUTY);

  logic [CNT_W-1:0]    r_blink_cnt;
  logic                r_blink_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_led;
  logic                w_pwm_on;
  logic                w_blink_wrap;

  assign w_pwm_on     = ({1'b0, r_pwm_cnt} < DUTY);
  assign w_blink_wrap = (r_blink_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!btn) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_pwm_cnt     <= '0;
      r_led         <= 1'b0;
    end else begin
      r_led     <= r_blink_phase & w_pwm_on;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  assign led0_b = r_led;

endmodule

// File: tb/tb_blinky.sv
// Self-checking bench: four blinky configurations share clock and button; a
// closed-form model of the LED versus run-edge count feeds an expectation queue.
module tb_blinky;

  logic clk;
  logic btn;
  logic led_full;
  logic led_dim;
  logic led_off;
  logic led_n1;

  int n_cmp;
  int n_mis;
  int k_run;
  logic [3:0] sb[$];

  blinky #(.BLINK_HALF_CYCLES(4), .PWM_BITS(2), .PWM_DUTY(4)) u_full (.clk(clk), .btn(btn), .led0_b(led_full));
  blinky #(.BLINK_HALF_CYCLES(8), .PWM_BITS(2), .PWM_DUTY(2)) u_dim  (.clk(clk), .btn(btn), .led0_b(led_dim));
  blinky #(.BLINK_HALF_CYCLES(4), .PWM_BITS(2), .PWM_DUTY(0)) u_off  (.clk(clk), .btn(btn), .led0_b(led_off));
  blinky #(.BLINK_HALF_CYCLES(1), .PWM_BITS(2), .PWM_DUTY(4)) u_n1   (.clk(clk), .btn(btn), .led0_b(led_n1));

  initial clk = 1'b0;
  always #8 clk = ~clk;

  // LED value after run edge k (k=0: just reset) for a given configuration.
  function automatic logic model_led(input int k, input int n, input int bits, input int duty);
    int pwm;
    int phase;
    if (k == 0) return 1'b0;
    pwm   = (k - 1) % (1 << bits);
    phase = ((k - 1) / n) % 2;
    return (phase == 1) && (pwm < duty);
  endfunction

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s t=%0t run_edge=%0d: got %b want %b", tag, $time, k_run, obs, exp);
    end
  endtask

  // Scoreboard: expectation pushed on each sampled edge, popped once outputs settle.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      k_run = btn ? k_run + 1 : 0;
      sb.push_back({model_led(k_run, 4, 2, 4), model_led(k_run, 8, 2, 2),
                    model_led(k_run, 4, 2, 0), model_led(k_run, 1, 2, 4)});
      #1;
      e = sb.pop_front();
      check_eq("full_duty", led_full, e[3]);
      check_eq("pwm_dim",   led_dim,  e[2]);
      check_eq("zero_duty", led_off,  e[1]);
      check_eq("n_eq_1",    led_n1,   e[0]);
    end
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    k_run = 0;
    btn   = 1'b0;

    // Initial reset for two edges, then run.
    repeat (2) @(posedge clk);
    @(negedge clk);
    btn = 1'b1;

    // Run five edges (LED lit on the full-duty unit), reset on the sixth.
    repeat (5) @(posedge clk);
    @(negedge clk);
    btn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    btn = 1'b1;

    // Short low glitch between edges must be ignored.
    repeat (9) @(posedge clk);
    @(negedge clk);
    btn = 1'b0;
    #2;
    btn = 1'b1;
    repeat (40) @(posedge clk);

    // Button pulses: low 20 ns, then toggle every 2000 ns, all off clock edges.
    @(negedge clk);
    btn = 1'b0;
    #20;
    btn = 1'b1;
    repeat (6) begin
      #2000;
      btn = ~btn;
    end
    #2000;
    btn = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
